// File: rtl/mul_acc_stage_if.sv
// Handshake bundle between the product source, the accumulate stage and the result consumer.
// The slave modport is the stage's view; the master modport is the surrounding system's view.
interface mul_acc_stage_if #(
   parameter int unsigned PROD_W = 16,
   parameter int unsigned ACC_W  = 24,
   parameter int unsigned CNT_W  = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_product;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_acc;
   logic [CNT_W-1:0]  out_count;
   logic              out_ovf;

   modport slave (
      input  in_valid, in_product, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_count, out_ovf
   );

   modport master (
      output in_valid, in_product, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_count, out_ovf
   );
endinterface

// File: rtl/mul_acc_stage.sv
// Accumulates a stream of unsigned products into a saturating sum and hands the finished sum
// downstream over valid/ready. ACCUM collects terms; HOLD presents the sum until consumed.
module mul_acc_stage #(
   parameter int unsigned PROD_W = 16,
   parameter int unsigned ACC_W  = 24,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   mul_acc_stage_if.slave       bus
);

   localparam int unsigned SumW = ACC_W + 1;

   typedef enum logic [0:0] {StAccum, StHold} state_e;

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               ovf_q, ovf_d;
   logic [SumW-1:0]    sum;

   // One extra bit catches the carry out of the accumulator.
   assign sum = {1'b0, acc_q} + SumW'(bus.in_product);

   // Next-state logic: clr aborts from any state and drops a coincident term.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (clr) begin
         state_d = StAccum;
         acc_d   = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            StAccum: begin
               if (bus.in_valid) begin
                  // An all-ones accumulator plus any nonzero term carries, so it stays pinned.
                  acc_d   = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
                  ovf_d   = ovf_q | sum[ACC_W];
                  count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
                  if (bus.in_last) begin
                     state_d = StHold;
                  end
               end
            end
            StHold: begin
               if (bus.out_ready) begin
                  state_d = StAccum;
                  acc_d   = '0;
                  count_d = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: state_d = StAccum;
         endcase
      end
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StAccum;
         acc_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Handshake flags depend only on state, so there is no out_ready -> in_ready path.
   assign bus.in_ready  = (state_q == StAccum);
   assign bus.out_valid = (state_q == StHold);
   assign bus.out_acc   = acc_q;
   assign bus.out_count = count_q;
   assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_mul_acc_stage.sv
// Directed bench for mul_acc_stage: inputs change on the falling edge, outputs are sampled on
// the falling edge, the DUT samples on the rising edge.
module tb_mul_acc_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr = 1'b0;
   int   checks = 0;
   int   failures = 0;

   mul_acc_stage_if #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) bus ();

   mul_acc_stage #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Present one term for one rising edge, return at the following falling edge.
   task automatic send(input logic [15:0] p, input logic last);
      bus.in_valid   = 1'b1;
      bus.in_product = p;
      bus.in_last    = last;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid   = 1'b0;
      bus.in_last    = 1'b0;
   endtask

   // One-cycle consume of the pending result.
   task automatic consume();
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
      end
      checks++;
      if ({bus.out_acc, bus.out_count, bus.out_ovf} !== 33'd0) begin
         failures++;
         $display("FAIL reset_outputs acc=%h cnt=%h ovf=%b want 0", bus.out_acc, bus.out_count,
                  bus.out_ovf);
      end
   endtask

   task automatic test_basic_sum();
      send(16'h0006, 1'b0);
      send(16'h000C, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL basic_early_valid got=%b want=0", bus.out_valid);
      end
      send(16'h0023, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL basic_latency valid=%b ready=%b want 1/0", bus.out_valid, bus.in_ready);
      end
      checks++;
      if (bus.out_acc !== 24'h000035 || bus.out_count !== 8'd3 || bus.out_ovf !== 1'b0) begin
         failures++;
         $display("FAIL basic_result acc=%h cnt=%0d ovf=%b want 000035/3/0", bus.out_acc,
                  bus.out_count, bus.out_ovf);
      end
      consume();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_acc !== 24'd0) begin
         failures++;
         $display("FAIL basic_after_hs ready=%b valid=%b acc=%h want 1/0/0", bus.in_ready,
                  bus.out_valid, bus.out_acc);
      end
   endtask

   task automatic test_zero_terms();
      send(16'h0000, 1'b0);
      send(16'h0000, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd0 || bus.out_count !== 8'd2) begin
         failures++;
         $display("FAIL zero_terms valid=%b acc=%h cnt=%0d want 1/0/2", bus.out_valid,
                  bus.out_acc, bus.out_count);
      end
      consume();
   endtask

   task automatic test_saturation();
      bus.in_valid   = 1'b1;
      bus.in_product = 16'hFE01;
      for (int i = 0; i < 300; i++) begin
         bus.in_last = (i == 299);
         @(posedge clk);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'hFFFFFF || bus.out_ovf !== 1'b1) begin
         failures++;
         $display("FAIL sat_acc valid=%b acc=%h ovf=%b want 1/ffffff/1", bus.out_valid,
                  bus.out_acc, bus.out_ovf);
      end
      checks++;
      if (bus.out_count !== 8'hFF) begin
         failures++; $display("FAIL sat_count got=%h want=ff", bus.out_count);
      end
      consume();
      send(16'h0001, 1'b1);
      checks++;
      if (bus.out_acc !== 24'd1 || bus.out_ovf !== 1'b0 || bus.out_count !== 8'd1) begin
         failures++;
         $display("FAIL sat_fresh acc=%h ovf=%b cnt=%0d want 1/0/1", bus.out_acc, bus.out_ovf,
                  bus.out_count);
      end
      consume();
   endtask

   task automatic test_backpressure();
      int bad = 0;
      int waited = 0;
      send(16'h0005, 1'b1);
      bus.in_valid   = 1'b1;
      bus.in_product = 16'h0007;
      bus.in_last    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_acc !== 24'd5 ||
             bus.out_count !== 8'd1)
            bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL bp_hold bad_cycles=%0d want=0 (acc=%h ready=%b)", bad, bus.out_acc,
                  bus.in_ready);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_acc !== 24'd0) begin
         failures++;
         $display("FAIL bp_bubble ready=%b acc=%h want 1/0", bus.in_ready, bus.out_acc);
      end
      while (bus.out_valid !== 1'b1 && waited < 20) begin
         @(posedge clk);
         @(negedge clk);
         waited++;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'd7 || bus.out_count !== 8'd1) begin
         failures++;
         $display("FAIL bp_next_term valid=%b acc=%h cnt=%0d want 1/7/1", bus.out_valid,
                  bus.out_acc, bus.out_count);
      end
      consume();
   endtask

   task automatic test_clear();
      send(16'h0010, 1'b0);
      send(16'h0020, 1'b0);
      clr            = 1'b1;
      bus.in_valid   = 1'b1;
      bus.in_product = 16'h0040;
      bus.in_last    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      clr          = 1'b0;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_acc !== 24'd0 || bus.out_count !== 8'd0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL clr_abort acc=%h cnt=%0d ready=%b want 0/0/1", bus.out_acc,
                  bus.out_count, bus.in_ready);
      end
      send(16'h0100, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_acc !== 24'h000100 || bus.out_count !== 8'd1) begin
         failures++;
         $display("FAIL clr_single valid=%b acc=%h cnt=%0d want 1/000100/1", bus.out_valid,
                  bus.out_acc, bus.out_count);
      end
      clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_acc !== 24'd0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL clr_hold valid=%b acc=%h ready=%b want 0/0/1", bus.out_valid,
                  bus.out_acc, bus.in_ready);
      end
   endtask

   task automatic test_reset_in_hold();
      send(16'h0003, 1'b0);
      send(16'h0004, 1'b1);
      rst           = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst           = 1'b0;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
          {bus.out_acc, bus.out_count, bus.out_ovf} !== 33'd0) begin
         failures++;
         $display("FAIL rst_hold valid=%b ready=%b acc=%h cnt=%0d want 0/1/0/0", bus.out_valid,
                  bus.in_ready, bus.out_acc, bus.out_count);
      end
      send(16'h0009, 1'b1);
      checks++;
      if (bus.out_acc !== 24'd9 || bus.out_count !== 8'd1) begin
         failures++;
         $display("FAIL rst_hold_next acc=%h cnt=%0d want 9/1", bus.out_acc, bus.out_count);
      end
      consume();
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_product = '0;
      bus.in_last    = 1'b0;
      bus.out_ready  = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic_sum();
      test_zero_terms();
      test_saturation();
      test_backpressure();
      test_clear();
      test_reset_in_hold();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
